// File: rtl/lcd_text_console_pkg.sv
// ============================================================================
// lcd_console_pkg : shared types and character constants for lcd_text_console
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_console_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SCR_RD = 3'd2,
        ST_SCR_WR = 3'd3,
        ST_BLANK  = 3'd4
    } state_e;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    localparam logic [7:0] DEF_FILL_CHAR = 8'h20;

    // Start address of each text line; the display driver scans with the same map
    localparam logic [5:0] LINE0_OFFSET = 6'd0;
    localparam logic [5:0] LINE1_OFFSET = 6'd16;
    localparam logic [5:0] LINE2_OFFSET = 6'd32;
    localparam logic [5:0] LINE3_OFFSET = 6'd48;

endpackage

`default_nettype wire

// File: rtl/lcd_text_console_if.sv
// ============================================================================
// lcd_text_console_if : character input handshake plus text-RAM write port
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_text_console_if #(
    parameter int ADDR_W = 6
) ();
    logic              ch_valid;
    logic [7:0]        ch_data;
    logic              ch_ready;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [1:0]        cur_row;
    logic [3:0]        cur_col;

    modport slave (
        input  ch_valid, ch_data, ram_rdata,
        output ch_ready, busy, ram_addr, ram_we, ram_wdata, cur_row, cur_col
    );

    modport master (
        output ch_valid, ch_data, ram_rdata,
        input  ch_ready, busy, ram_addr, ram_we, ram_wdata, cur_row, cur_col
    );
endinterface

`default_nettype wire

// File: rtl/lcd_text_console.sv
// ============================================================================
// lcd_text_console : cursor-tracking character writer for a 4x16 text RAM,
// with clear and scroll-up jobs. Optional LCD_CONSOLE_AUTOWRAP_EN wraps col 15.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_text_console
    import lcd_console_pkg::*;
#(
    parameter int         ROWS      = 4,
    parameter int         COLS      = 16,
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] FILL_CHAR = DEF_FILL_CHAR
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    lcd_text_console_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_last_cell  = ADDR_W'(ROWS*COLS - 1);
    localparam logic [ADDR_W-1:0] c_scr_last   = ADDR_W'((ROWS-1)*COLS - 1);
    localparam logic [ADDR_W-1:0] c_blank_base = ADDR_W'((ROWS-1)*COLS);
    localparam logic [ADDR_W-1:0] c_blank_last = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] c_line       = ADDR_W'(COLS);
    localparam logic [3:0]        c_col_last   = 4'(COLS - 1);
    localparam logic [1:0]        c_row_last   = 2'(ROWS - 1);

    state_e            state_q, state_d, eff_state;
    logic [ADDR_W-1:0] cnt_q, cnt_d, eff_cnt;
    logic [1:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              copy_q, copy_d;
    logic              ready_q, ready_d;
    logic              wrap_pend_q, wrap_pend_d;

    logic              accept;
    logic              printable;
    logic [ADDR_W-1:0] cur_addr;

    assign accept    = bus.ch_valid & ready_q;
    assign printable = (bus.ch_data >= PRINT_MIN) && (bus.ch_data <= PRINT_MAX);
    assign cur_addr  = ADDR_W'(int'(row_q) * COLS + int'(col_q));

    // The state/counter pair names the RAM operation issued this cycle (visible
    // next cycle); IDLE issues op 0 of a job itself so no cycle is lost on entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        copy_d      = 1'b0;
        wrap_pend_d = wrap_pend_q;
        eff_state   = state_q;
        eff_cnt     = cnt_q;

        if (state_q == ST_IDLE) begin
            eff_cnt = '0;
            if (wrap_pend_q) begin
                wrap_pend_d = 1'b0;
                eff_state   = ST_SCR_RD;
            end else if (accept) begin
                if (printable) begin
                    we_d    = 1'b1;
                    addr_d  = cur_addr;
                    wdata_d = bus.ch_data;
                    if (col_q != c_col_last) begin
                        col_d = col_q + 4'd1;
                    end else begin
`ifdef LCD_CONSOLE_AUTOWRAP_EN
                        col_d = 4'd0;
                        if (row_q != c_row_last) row_d = row_q + 2'd1;
                        else                     wrap_pend_d = 1'b1;
`else
                        col_d = col_q;
`endif
                    end
                end else begin
                    case (bus.ch_data)
                        CH_LF: begin
                            col_d = 4'd0;
                            if (row_q != c_row_last) row_d = row_q + 2'd1;
                            else                     eff_state = ST_SCR_RD;
                        end
                        CH_CR: col_d = 4'd0;
                        CH_BS: begin
                            if (col_q != 4'd0) begin
                                col_d   = col_q - 4'd1;
                                we_d    = 1'b1;
                                addr_d  = cur_addr - ADDR_W'(1);
                                wdata_d = FILL_CHAR;
                            end
                        end
                        CH_FF: begin
                            row_d     = 2'd0;
                            col_d     = 4'd0;
                            eff_state = ST_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
        end

        case (eff_state)
            ST_CLEAR: begin
                we_d    = 1'b1;
                addr_d  = eff_cnt;
                wdata_d = FILL_CHAR;
                state_d = (eff_cnt == c_last_cell) ? ST_IDLE : ST_CLEAR;
                cnt_d   = (eff_cnt == c_last_cell) ? '0 : eff_cnt + ADDR_W'(1);
            end
            ST_SCR_RD: begin
                addr_d  = eff_cnt + c_line;
                state_d = ST_SCR_WR;
                cnt_d   = eff_cnt;
            end
            ST_SCR_WR: begin
                we_d    = 1'b1;
                addr_d  = eff_cnt;
                copy_d  = 1'b1;
                state_d = (eff_cnt == c_scr_last) ? ST_BLANK : ST_SCR_RD;
                cnt_d   = (eff_cnt == c_scr_last) ? '0 : eff_cnt + ADDR_W'(1);
            end
            ST_BLANK: begin
                we_d    = 1'b1;
                addr_d  = eff_cnt + c_blank_base;
                wdata_d = FILL_CHAR;
                state_d = (eff_cnt == c_blank_last) ? ST_IDLE : ST_BLANK;
                cnt_d   = (eff_cnt == c_blank_last) ? '0 : eff_cnt + ADDR_W'(1);
            end
            default: ;
        endcase

        // Ready rises one cycle after the last job write has been presented.
        ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE) && !wrap_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            row_q       <= 2'd0;
            col_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            copy_q      <= 1'b0;
            ready_q     <= 1'b0;
            wrap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            copy_q      <= copy_d;
            ready_q     <= ready_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    assign bus.ch_ready  = ready_q;
    assign bus.busy      = ~ready_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    // Scroll writes forward the byte read one cycle earlier straight from the RAM.
    assign bus.ram_wdata = copy_q ? bus.ram_rdata : wdata_q;
    assign bus.cur_row   = row_q;
    assign bus.cur_col   = col_q;

endmodule

`default_nettype wire
